req_grant_initiator: RTL and testbench

//   Synthesizable initiator side of the IFU req/grant fetch handshake. Raises req, holds it until
//   the responder returns grant, and captures the payload sampled in the grant cycle into an

---
 rtl/req_grant_initiator.sv | 144 ++++++++++++++
 tb/tb_req_grant_initiator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/req_grant_initiator.sv
// Initiator side of the IFU req/grant fetch handshake with a first-word-fall-through payload FIFO.
// Optional request timeout with sticky error flag is enabled by defining REQ_TIMEOUT_EN.
module req_grant_initiator #(
  parameter int unsigned payload_width    = 32,
  parameter int unsigned fifo_depth       = 4,
  parameter int unsigned timeout_cycles   = 64,
  parameter real         simulation_delay = 1.0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     flush,
  output logic                     req,
  input  logic                     grant,
  input  logic [payload_width-1:0] payload,
  output logic [payload_width-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     timeout_err
);

  localparam int unsigned AW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int unsigned CW = AW + 1;

  // Elaboration-time parameter sanity checks
  if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0) begin : g_bad_depth
    $error("fifo_depth must be a power of 2 and >= 2");
  end
  if (timeout_cycles < 1) begin : g_bad_timeout
    $error("timeout_cycles must be >= 1");
  end
  if (simulation_delay < 0.0) begin : g_bad_delay
    $error("simulation_delay must be non-negative");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1
`ifdef REQ_TIMEOUT_EN
    , ERR = 2'd2
`endif
  } state_t;

  state_t                   state, state_nxt;
  logic [payload_width-1:0] mem [fifo_depth];
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            count, cnt_nxt;
  logic                     push, pop, space, timeout_hit;

  assign req     = (state == REQ);
  assign m_valid = (count != '0);
  assign m_data  = mem[rd_ptr];
  assign push    = req & grant & ~flush;
  assign pop     = m_valid & m_ready & ~flush;
  assign cnt_nxt = count + CW'(push) - CW'(pop);
  assign space   = (cnt_nxt < CW'(fifo_depth));

`ifdef REQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(timeout_cycles + 1);

  logic [TW-1:0] wait_cnt;
  logic          err_q;

  // The last waiting cycle ends with req dropping, so req is high for exactly timeout_cycles
  assign timeout_hit = (state == REQ) & ~grant & (wait_cnt == TW'(timeout_cycles - 1));
  assign timeout_err = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else if (flush || push) begin
      wait_cnt <= '0;
    end else if (timeout_hit) begin
      wait_cnt <= '0;
      err_q    <= 1'b1;
    end else if (state == REQ && !grant) begin
      wait_cnt <= wait_cnt + TW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: an open request is held until grant, flush or timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!flush && en && space) state_nxt = REQ;
      end
      REQ: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (push) begin
          state_nxt = (en && space) ? REQ : IDLE;
        end else if (timeout_hit) begin
`ifdef REQ_TIMEOUT_EN
          state_nxt = ERR;
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef REQ_TIMEOUT_EN
      ERR: begin
        if (flush) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage and pointers; flush empties the FIFO and drops any same-cycle push/pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(fifo_depth); i++) mem[i] <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= payload;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_req_grant_initiator.sv
// Directed and scoreboard bench for req_grant_initiator; timeout scenario runs when REQ_TIMEOUT_EN is defined.
module tb_req_grant_initiator;

  logic        clk = 1'b0;
  logic        rst_n, en, flush, gnt_allow, m_ready;
  logic        req, grant, m_valid, timeout_err;
  logic [31:0] payload, m_data;
  int          checks = 0;
  int          errors = 0;

  // Responder: grant is combinational from req
  assign grant = req & gnt_allow;

  always #5 clk = ~clk;

  req_grant_initiator #(
    .payload_width(32), .fifo_depth(4), .timeout_cycles(8), .simulation_delay(1.0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .req(req), .grant(grant),
    .payload(payload), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .timeout_err(timeout_err)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; gnt_allow = 1'b0; m_ready = 1'b0; payload = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; flush = 1'b0; gnt_allow = 1'b1; m_ready = 1'b0; payload = 32'hdead_beef;
    tick(); tick();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    checks++; if (m_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", m_data); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    en = 1'b1; gnt_allow = 1'b1; m_ready = 1'b1;
    tick();
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL basic_req_rise: got %b want 1", req); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_valid0: got %b want 0", m_valid); end
    for (int i = 0; i < 3; i++) begin
      payload = 32'(2016 + 4 * i);
      if (i == 2) en = 1'b0;
      tick();
      checks++;
      if (m_valid !== 1'b1 || m_data !== 32'(2016 + 4 * i)) begin
        errors++; $display("FAIL basic_data%0d: got v=%b d=%0d want v=1 d=%0d", i, m_valid, m_data, 2016 + 4 * i);
      end
    end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL basic_req_fall: got %b want 0", req); end
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got %b want 0", m_valid); end
  endtask

  task automatic test_full();
    logic [31:0] exp_q [4];
    exp_q[0] = 32'd101; exp_q[1] = 32'd102; exp_q[2] = 32'd103; exp_q[3] = 32'd200;
    do_reset();
    en = 1'b1; gnt_allow = 1'b1; m_ready = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++; if (req !== 1'b1) begin errors++; $display("FAIL full_req%0d: got %b want 1", k, req); end
      payload = 32'(100 + k);
      tick();
    end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL full_req_drop: got %b want 0", req); end
    checks++; if (m_data !== 32'd100) begin errors++; $display("FAIL full_head: got %0d want 100", m_data); end
    tick();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL full_req_hold0: got %b want 0", req); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL full_rereq: got %b want 1", req); end
    checks++; if (m_data !== 32'd101) begin errors++; $display("FAIL full_head2: got %0d want 101", m_data); end
    payload = 32'd200;
    tick();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL full_req_drop2: got %b want 0", req); end
    en = 1'b0; gnt_allow = 1'b0; m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp_q[k]) begin
        errors++; $display("FAIL full_drain%0d: got v=%b d=%0d want v=1 d=%0d", k, m_valid, m_data, exp_q[k]);
      end
      tick();
    end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL full_empty: got %b want 0", m_valid); end
  endtask

  task automatic test_delayed_grant();
    do_reset();
    en = 1'b1; gnt_allow = 1'b0; m_ready = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      checks++; if (req !== 1'b1) begin errors++; $display("FAIL delay_hold%0d: got %b want 1", c, req); end
      if (c == 0) en = 1'b0;
      if (c == 2) begin gnt_allow = 1'b1; payload = 32'd3030; end
      tick();
    end
    gnt_allow = 1'b0;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL delay_idle: got %b want 0", req); end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'd3030) begin
      errors++; $display("FAIL delay_data: got v=%b d=%0d want v=1 d=3030", m_valid, m_data);
    end
    tick();
    checks++; if (m_valid !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL delay_after: got v=%b r=%b want 0 0", m_valid, req); end
  endtask

  task automatic test_flush();
    do_reset();
    en = 1'b1; gnt_allow = 1'b1; m_ready = 1'b0;
    tick();
    payload = 32'd2036; tick();
    payload = 32'd2040; tick();
    checks++; if (m_valid !== 1'b1 || m_data !== 32'd2036) begin errors++; $display("FAIL flush_pre: got v=%b d=%0d want v=1 d=2036", m_valid, m_data); end
    payload = 32'd2044; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", m_valid); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL flush_req: got %b want 0", req); end
    payload = 32'd2048;
    tick();
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL flush_rereq: got %b want 1", req); end
    en = 1'b0;
    tick();
    checks++; if (m_valid !== 1'b1 || m_data !== 32'd2048) begin errors++; $display("FAIL flush_newdata: got v=%b d=%0d want v=1 d=2048", m_valid, m_data); end
    m_ready = 1'b1;
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_drain: got %b want 0", m_valid); end
    m_ready = 1'b0; gnt_allow = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] q [$];
    int pushed = 0, popped = 0, waited = 0, cyc = 0, dly;
    logic prev_wait = 1'b0;
    do_reset();
    en = 1'b1;
    dly = int'($urandom_range(0, 3));
    while ((pushed < 1000 || q.size() != 0 || req) && cyc < 20000) begin
      if (prev_wait) begin
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL rand_req_drop: cycle %0d got %b want 1", cyc, req); end
      end
      gnt_allow = 1'b0;
      if (req) begin
        if (waited >= dly) begin
          gnt_allow = 1'b1; payload = $urandom; q.push_back(payload); pushed++;
          waited = 0; dly = int'($urandom_range(0, 3));
        end else begin
          waited++;
        end
      end
      prev_wait = req && !gnt_allow;
      m_ready = 1'($urandom_range(0, 1));
      if (m_valid && m_ready) begin
        checks++;
        if (q.size() == 0 || m_data !== q[0]) begin
          errors++; $display("FAIL rand_data: pop %0d got %h want %h", popped, m_data, (q.size() != 0) ? q[0] : 32'hx);
        end
        if (q.size() != 0) void'(q.pop_front());
        popped++;
      end
      if (pushed >= 1000) en = 1'b0;
      tick();
      cyc++;
    end
    checks++; if (cyc >= 20000) begin errors++; $display("FAIL rand_budget: got %0d cycles want < 20000", cyc); end
    checks++; if (popped !== pushed) begin errors++; $display("FAIL rand_count: got %0d pops want %0d", popped, pushed); end
    gnt_allow = 1'b0; m_ready = 1'b0;
  endtask

`ifdef REQ_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    en = 1'b1; gnt_allow = 1'b0; m_ready = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) begin
      checks++; if (req !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_wait%0d: got r=%b e=%b want 1 0", k, req, timeout_err); end
      tick();
    end
    checks++; if (req !== 1'b0 || timeout_err !== 1'b1) begin errors++; $display("FAIL to_fire: got r=%b e=%b want 0 1", req, timeout_err); end
    tick();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL to_err_hold: got %b want 0", req); end
    en = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; en = 1'b1;
    checks++; if (req !== 1'b0 || timeout_err !== 1'b1) begin errors++; $display("FAIL to_flush: got r=%b e=%b want 0 1", req, timeout_err); end
    tick();
    checks++; if (req !== 1'b1 || timeout_err !== 1'b1) begin errors++; $display("FAIL to_rereq: got r=%b e=%b want 1 1", req, timeout_err); end
    do_reset();
    checks++; if (timeout_err !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL to_reset: got r=%b e=%b want 0 0", req, timeout_err); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_delayed_grant();
    test_flush();
    test_random();
`ifdef REQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
